// File: rtl/oam_dma_ctrl.sv
// Sprite-memory DMA engine: snoops a CPU write to the trigger register, halts the CPU,
// then copies a 256-byte page to the fixed destination port as read/write pairs.
module oam_dma_ctrl #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    REG_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] TRIG_ADDR  = 16'h4014,
  parameter logic [ADDR_WIDTH-1:0] DEST_ADDR  = 16'h2004
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [REG_WIDTH-1:0]  cpu_wdata,
  input  logic                  cpu_we,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic                  rdy,
  output logic                  bus_grant,
  output logic [ADDR_WIDTH-1:0] dma_addr,
  output logic [REG_WIDTH-1:0]  dma_wdata,
  output logic                  dma_we,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                  state_r;
  logic [REG_WIDTH-1:0]    page_r;
  logic [7:0]              idx_r;
  logic                    parity_r;
  logic                    rdy_r;
  logic                    bus_grant_r;
  logic [ADDR_WIDTH-1:0]   dma_addr_r;
  logic                    dma_we_r;
  logic                    busy_r;
  logic                    trig_hit_s;

  function automatic logic [ADDR_WIDTH-1:0] src_addr(input logic [REG_WIDTH-1:0] pg,
                                                     input logic [7:0]           ix);
    return ADDR_WIDTH'({pg, ix});
  endfunction

  assign trig_hit_s = cpu_we && (cpu_addr == TRIG_ADDR);

  // Free-running cycle parity; decides whether the halt exit needs an alignment cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= ~parity_r;
    end
  end

  // Transfer sequencer; outputs are loaded together with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      page_r      <= {REG_WIDTH{1'b0}};
      idx_r       <= 8'd0;
      rdy_r       <= 1'b1;
      bus_grant_r <= 1'b0;
      dma_addr_r  <= {ADDR_WIDTH{1'b0}};
      dma_we_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (trig_hit_s) begin
            state_r <= HALT;
            page_r  <= cpu_wdata;
            idx_r   <= 8'd0;
            rdy_r   <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        HALT: begin
          // A CPU write cycle cannot be stalled, so wait for a read cycle before taking the bus.
          if (!cpu_we) begin
            if (parity_r) begin
              state_r <= ALIGN;
            end else begin
              state_r     <= READ;
              bus_grant_r <= 1'b1;
              dma_addr_r  <= src_addr(page_r, idx_r);
            end
          end
        end
        ALIGN: begin
          state_r     <= READ;
          bus_grant_r <= 1'b1;
          dma_addr_r  <= src_addr(page_r, idx_r);
        end
        READ: begin
          state_r    <= WRITE;
          dma_addr_r <= DEST_ADDR;
          dma_we_r   <= 1'b1;
        end
        WRITE: begin
          idx_r    <= idx_r + 8'd1;
          dma_we_r <= 1'b0;
          if (idx_r == 8'hFF) begin
            state_r     <= DONE;
            rdy_r       <= 1'b1;
            bus_grant_r <= 1'b0;
            dma_addr_r  <= {ADDR_WIDTH{1'b0}};
          end else begin
            state_r    <= READ;
            dma_addr_r <= src_addr(page_r, idx_r + 8'd1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          rdy_r       <= 1'b1;
          bus_grant_r <= 1'b0;
          dma_addr_r  <= {ADDR_WIDTH{1'b0}};
          dma_we_r    <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign rdy       = rdy_r;
  assign bus_grant = bus_grant_r;
  assign dma_addr  = dma_addr_r;
  assign dma_we    = dma_we_r;
  assign busy      = busy_r;
  // Read data is forwarded in the same cycle it arrives from memory.
  assign dma_wdata = (state_r == WRITE) ? mem_rdata : {REG_WIDTH{1'b0}};

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized self-checking bench for oam_dma_ctrl against a timeline model of a transfer.
module tb_oam_dma_ctrl;

  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] DEST = 16'h2004;

  logic        clk;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [7:0]  mem_rdata;
  logic        rdy;
  logic        bus_grant;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_we;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  bit started = 1'b0;

  // model: edges since reset release, transfer phase and position after halt exit
  int       m_edges;
  bit       m_busy, m_halt;
  int       m_pos, m_align;
  logic [7:0] m_page;

  // measurements of the current transfer
  int          rdy_low, we_cnt;
  bit          seen_rd;
  logic [15:0] first_rd, last_rd;
  logic [7:0]  last_wd;

  oam_dma_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .mem_rdata (mem_rdata),
    .rdy       (rdy),
    .bus_grant (bus_grant),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_we    (dma_we),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return (a[7:0] * 8'd3) ^ a[15:8] ^ 8'hA5;
  endfunction

  // memory returns data one cycle after the address
  always @(posedge clk) mem_rdata <= mem_f(bus_grant ? dma_addr : cpu_addr);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_edges <= 0; m_busy <= 1'b0; m_halt <= 1'b0;
      m_pos <= 0; m_align <= 0; m_page <= 8'h00;
    end else begin
      m_edges <= m_edges + 1;
      if (!m_busy) begin
        if (cpu_we && cpu_addr == TRIG) begin
          m_busy <= 1'b1; m_halt <= 1'b1; m_page <= cpu_wdata;
        end
      end else if (m_halt) begin
        if (!cpu_we) begin
          m_halt <= 1'b0; m_align <= m_edges % 2; m_pos <= 0;
        end
      end else if (m_pos == m_align + 512) begin
        m_busy <= 1'b0;
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  function automatic logic [27:0] exp_vec();
    logic r, g, w, b;
    logic [15:0] a;
    logic [7:0] d, ix;
    int p;
    r = 1'b1; g = 1'b0; w = 1'b0; b = 1'b0; a = 16'h0000; d = 8'h00;
    if (m_busy) begin
      b = 1'b1; r = 1'b0;
      if (!m_halt) begin
        p = m_pos - m_align;
        ix = 8'(p / 2);
        if (p >= 512) begin
          r = 1'b1;
        end else if (p >= 0) begin
          g = 1'b1;
          if (p % 2 == 0) a = {m_page, ix};
          else begin a = DEST; w = 1'b1; d = mem_f({m_page, ix}); end
        end
      end
    end
    return {r, g, w, b, a, d};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (started) check("cycle", {rdy, bus_grant, dma_we, busy, dma_addr, dma_wdata}, exp_vec());
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (!rdy) rdy_low <= rdy_low + 1;
      if (dma_we) begin we_cnt <= we_cnt + 1; last_wd <= dma_wdata; end
      if (bus_grant && !dma_we) begin
        if (!seen_rd) first_rd <= dma_addr;
        seen_rd <= 1'b1;
        last_rd <= dma_addr;
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic start_trigger(input logic [7:0] pg);
    rdy_low = 0; we_cnt = 0; seen_rd = 1'b0;
    cpu_we = 1'b1; cpu_addr = TRIG; cpu_wdata = pg;
    step();
  endtask

  task automatic run_xfer(input logic [7:0] pg, input int par, input int hold,
                          input bit noise, input logic [7:0] done_pg);
    int  align;
    int  p;
    bit  fin;
    cpu_we = 1'b0;
    if (par >= 0 && ((m_edges + 1 + hold) % 2) != par) step();
    align = (m_edges + 1 + hold) % 2;
    start_trigger(pg);
    for (int h = 0; h < hold; h++) begin
      cpu_we = 1'b1; cpu_addr = 16'(16'h0100 + $urandom_range(0, 255)); cpu_wdata = 8'($urandom);
      step();
    end
    cpu_we = 1'b0;
    fin = 1'b0;
    for (int c = 0; c < 1200 && !fin; c++) begin
      step();
      if (!m_busy) begin
        fin = 1'b1;
      end else begin
        p = m_pos - m_align;
        cpu_we = 1'b0;
        if (!m_halt && p == 512 && done_pg != 8'h00) begin
          cpu_we = 1'b1; cpu_addr = TRIG; cpu_wdata = done_pg;
        end else if (!m_halt && noise && p == 16'h81) begin
          cpu_we = 1'b1; cpu_addr = TRIG; cpu_wdata = 8'h05;
        end else if (!m_halt && noise && p >= 0 && p < 508) begin
          cpu_we = 1'($urandom);
          cpu_addr = ($urandom_range(0, 3) == 0) ? TRIG : 16'($urandom);
          cpu_wdata = 8'($urandom);
        end
      end
    end
    cpu_we = 1'b0;
    if (!fin) begin
      n_chk++;
      $display("FAIL xfer_timeout: page %h still busy after 1200 cycles", pg);
    end else begin
      check("rdy_low_cycles", 32'(rdy_low), 32'(513 + hold + align));
      check("write_count", 32'(we_cnt), 32'd256);
      check("first_read", {16'h0, first_rd}, {16'h0, pg, 8'h00});
      check("last_read", {16'h0, last_rd}, {16'h0, pg, 8'hFF});
      check("last_wdata", {24'h0, last_wd}, {24'h0, mem_f({pg, 8'hFF})});
    end
  endtask

  task automatic reset_mid(input logic [7:0] pg);
    bit hit;
    start_trigger(pg);
    cpu_we = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 800 && !hit; c++) begin
      step();
      if (m_busy && !m_halt && (m_pos - m_align) == 257) hit = 1'b1;
    end
    if (!hit) begin
      n_chk++;
      $display("FAIL mid_timeout: write of idx 80 not reached");
    end else begin
      check("mid_write_we", {31'h0, dma_we}, 32'd1);
      check("mid_write_addr", {16'h0, dma_addr}, {16'h0, DEST});
    end
    #1 reset_n = 1'b0;
    #1 check("async_reset", {rdy, bus_grant, dma_we, busy, dma_addr, dma_wdata},
             {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00});
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    rdy_low = 0; we_cnt = 0; seen_rd = 1'b0;
    first_rd = 16'h0; last_rd = 16'h0; last_wd = 8'h0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    started = 1'b1;
    #1 check("reset_state", {rdy, bus_grant, dma_we, busy, dma_addr, dma_wdata},
             {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00});
    step();
    run_xfer(8'h02, 0, 0, 1'b0, 8'h00);
    run_xfer(8'h02, 1, 0, 1'b0, 8'h00);
    run_xfer(8'h02, 0, 2, 1'b0, 8'h00);
    run_xfer(8'h02, 0, 0, 1'b1, 8'h33);
    run_xfer(8'hFF, -1, 0, 1'b0, 8'h00);
    reset_mid(8'h7E);
    run_xfer(8'h11, -1, 0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      run_xfer(8'($urandom_range(1, 255)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), 1'b1, 8'h00);
    end
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, default 16, address bus width.
REQ-002 Parameter: REG_WIDTH, default 8, data bus width.
REQ-003 Parameter: TRIG_ADDR, default 16'h4014, CPU write address that starts a transfer.
REQ-004 Parameter: DEST_ADDR, default 16'h2004, fixed destination address of every DMA write.
REQ-005 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-006 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-007 Port: cpu_addr  input  ADDR_WIDTH  CPU address bus A.
REQ-008 Port: cpu_wdata  input  REG_WIDTH  CPU write data.
REQ-009 Port: cpu_we  input  1  CPU write strobe, inverse of R_W_n.
REQ-010 Port: mem_rdata  input  REG_WIDTH  memory read data, valid in the cycle after a read address is driven.
REQ-011 Port: rdy  output  1  CPU ready; low halts the CPU.
REQ-012 Port: bus_grant  output  1  high selects DMA address, data and we onto the memory bus.
REQ-013 Port: dma_addr  output  ADDR_WIDTH  DMA address.
REQ-014 Port: dma_wdata  output  REG_WIDTH  DMA write data.
REQ-015 Port: dma_we  output  1  DMA write strobe.
REQ-016 Port: busy  output  1  high from trigger until DONE exits.

Function
REQ-017 States: IDLE, HALT, ALIGN, READ, WRITE, DONE; encoded FSM, one state register.
REQ-018 Free-running parity bit toggles every cycle from reset (0 in first cycle after reset release).
REQ-019 IDLE: cpu_we=1 and cpu_addr==TRIG_ADDR -> latch page=cpu_wdata, idx=0, go HALT next cycle.
REQ-020 HALT: rdy=0, bus_grant=0; stay while cpu_we=1 (CPU writes are not halted); when cpu_we=0 go ALIGN if parity=1, else READ.
REQ-021 ALIGN: one cycle, rdy=0, bus_grant=0, then READ.
REQ-022 READ: rdy=0, bus_grant=1, dma_addr={page,idx}, dma_we=0, then WRITE.
REQ-023 WRITE: rdy=0, bus_grant=1, dma_addr=DEST_ADDR, dma_we=1, dma_wdata=mem_rdata (combinational pass-through); idx increments at cycle end.
REQ-024 WRITE with idx==8'hFF -> DONE; otherwise -> READ.
REQ-025 DONE: one cycle, rdy=1, bus_grant=0, busy=1, then IDLE.
REQ-026 idx is 8-bit; wrap from FF to 00 ends the transfer, exactly 256 read/write pairs; page never increments.
REQ-027 Transfer length from HALT exit: 512 cycles (parity 0) or 513 (parity 1), excluding write-hold cycles.
REQ-028 Trigger writes while busy=1 are ignored; page unchanged.
REQ-029 Trigger write in the DONE cycle is ignored; trigger in IDLE the cycle after DONE is accepted.
REQ-030 Outside READ/WRITE: bus_grant=0, dma_we=0, dma_addr=0, dma_wdata=0.
REQ-031 Writes to TRIG_ADDR pass through to memory unchanged; the block only snoops.

Reset
REQ-032 reset_n=0 forces IDLE immediately, regardless of clk: rdy=1, bus_grant=0, dma_we=0, busy=0, dma_addr=0, dma_wdata=0, page=0, idx=0, parity=0.
REQ-033 Reset mid-transfer abandons it; no resume; the first trigger after reset release starts a full new transfer.

Verification
REQ-034 Trigger 8'h02 with parity 0, cpu_we low next -> 256 writes to 16'h2004 with data of 16'h0200..16'h02FF in order; rdy low 513 cycles total including HALT.
REQ-035 Same trigger with parity 1 -> one ALIGN cycle inserted; rdy low 514 cycles; data identical.
REQ-036 cpu_we held high 2 extra cycles after trigger -> stay in HALT 2 extra cycles, bus_grant stays 0, then normal transfer.
REQ-037 Second trigger 8'h05 at idx=8'h40 -> ignored; all 256 reads stay in page 8'h02.
REQ-038 Trigger 8'hFF -> reads 16'hFF00..16'hFFFF, last WRITE at idx FF, then DONE, no address wrap to 16'h0000.
REQ-039 reset_n low at idx=8'h80 mid-WRITE -> outputs take reset values asynchronously; new trigger after release restarts at idx 0.
